// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a two-register write bus.
// Scans digits DRIVE -> GUARD -> next digit; display data is shadowed per frame to avoid tearing.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_we,
    input  logic                  bus_addr,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           bus_rdata,
    output logic [3:0]            hex_nibble,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  digit_blank
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W   = $clog2(BLINK_FRAMES + 1);

    localparam logic [31:0] CTRL_MASK  = 32'h0000_0007 | (((32'h1 << NUM_DIGITS) - 32'h1) << 8);
    localparam logic [31:0] CTRL_RESET = 32'h0000_FF01 & CTRL_MASK;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRM_W-1:0]        frame_q, frame_d;
    logic                    phase_q, phase_d;
    logic [31:0]             value_q, value_d;
    logic [31:0]             ctrl_q, ctrl_d;
    logic [31:0]             shadow_value_q, shadow_value_d;
    logic [31:0]             shadow_ctrl_q, shadow_ctrl_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [3:0]              hex_nibble_q, hex_nibble_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    digit_blank_q, digit_blank_d;
    logic                    advance;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [NUM_DIGITS-1:0]   digit_mask;

    // Register file; the read path deliberately returns the pre-write value.
    always_comb begin
        value_d = value_q;
        ctrl_d  = ctrl_q;
        if (bus_we) begin
            if (bus_addr) begin
                ctrl_d = bus_wdata & CTRL_MASK;
            end else begin
                value_d = bus_wdata;
            end
        end
        rdata_d = bus_addr ? ctrl_q : value_q;
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        frame_d        = frame_q;
        phase_d        = phase_q;
        shadow_value_d = shadow_value_q;
        shadow_ctrl_d  = shadow_ctrl_q;
        advance        = 1'b0;
        // Disable bypasses the shadow so the display goes dark immediately.
        if (!ctrl_d[0]) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            frame_d = '0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d        = DRIVE;
                    idx_d          = '0;
                    cnt_d          = '0;
                    frame_d        = '0;
                    phase_d        = 1'b0;
                    shadow_value_d = value_d;
                    shadow_ctrl_d  = ctrl_d;
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        cnt_d = '0;
                        if (GUARD_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = GUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        state_d = DRIVE;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (advance) begin
                if (idx_q == IDX_LAST) begin
                    idx_d          = '0;
                    shadow_value_d = value_d;
                    shadow_ctrl_d  = ctrl_d;
                    if (frame_q == FRM_LAST) begin
                        frame_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    // A digit is a leading zero when it and every more-significant digit are zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_first
                assign lz_vec[gi] = 1'b0;
            end else begin : g_upper
                assign lz_vec[gi] = shadow_ctrl_d[1] &&
                                    (shadow_value_d[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign digit_mask = shadow_ctrl_d[8 +: NUM_DIGITS];

    // Outputs come from next-state values so all three change on the same edge.
    always_comb begin
        hex_nibble_d  = 4'h0;
        digit_sel_d   = '0;
        digit_blank_d = 1'b1;
        if (state_d == DRIVE) begin
            digit_sel_d   = NUM_DIGITS'(1) << idx_d;
            hex_nibble_d  = shadow_value_d[{idx_d, 2'b00} +: 4];
            digit_blank_d = !digit_mask[idx_d] || (shadow_ctrl_d[2] && phase_d) || lz_vec[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            frame_q        <= '0;
            phase_q        <= 1'b0;
            value_q        <= '0;
            ctrl_q         <= CTRL_RESET;
            shadow_value_q <= '0;
            shadow_ctrl_q  <= '0;
            rdata_q        <= '0;
            hex_nibble_q   <= 4'h0;
            digit_sel_q    <= '0;
            digit_blank_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            frame_q        <= frame_d;
            phase_q        <= phase_d;
            value_q        <= value_d;
            ctrl_q         <= ctrl_d;
            shadow_value_q <= shadow_value_d;
            shadow_ctrl_q  <= shadow_ctrl_d;
            rdata_q        <= rdata_d;
            hex_nibble_q   <= hex_nibble_d;
            digit_sel_q    <= digit_sel_d;
            digit_blank_q  <= digit_blank_d;
        end
    end

    assign bus_rdata   = rdata_q;
    assign hex_nibble  = hex_nibble_q;
    assign digit_sel   = digit_sel_q;
    assign digit_blank = digit_blank_q;

endmodule
